// File: rtl/clz_clo_seq.sv
// Sequential leading-zero / leading-one counter and normalizer.
// A 5-step binary search (16,8,4,2,1) takes one clock per step.
module clz_clo_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] a,
    output logic        busy,
    output logic        done,
    output logic [5:0]  count,
    output logic [31:0] norm
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_x;
    logic [5:0]  r_cnt;
    logic [2:0]  r_step;
    logic        r_f;
    logic [5:0]  r_count;
    logic [31:0] r_norm;

    logic [5:0]  w_w;
    logic [31:0] w_mask;
    logic [31:0] w_fill;
    logic        w_hit;
    logic [31:0] w_x_nxt;
    logic [5:0]  w_cnt_nxt;

    // Window of width w at the top of x, compared against the fill bit.
    always_comb begin
        w_w       = 6'd16 >> r_step;
        w_mask    = ~(32'hFFFF_FFFF >> w_w);
        w_fill    = r_f ? w_mask : 32'h0;
        w_hit     = (r_x & w_mask) == w_fill;
        w_x_nxt   = w_hit ? (r_x << w_w) : r_x;
        w_cnt_nxt = w_hit ? (r_cnt + w_w) : r_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= 32'h0;
            r_cnt   <= 6'd0;
            r_step  <= 3'd0;
            r_f     <= 1'b0;
            r_count <= 6'd0;
            r_norm  <= 32'h0;
        end else begin
            case (r_state)
                S_SEARCH: begin
                    r_x    <= w_x_nxt;
                    r_cnt  <= w_cnt_nxt;
                    r_step <= r_step + 3'd1;
                    if (r_step == 3'd4) begin
                        // Bit 31 still fill after 31 shifts: operand was all fill.
                        if (w_x_nxt[31] == r_f) begin
                            r_count <= 6'd32;
                            r_norm  <= 32'h0;
                        end else begin
                            r_count <= w_cnt_nxt;
                            r_norm  <= w_x_nxt;
                        end
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    if (start) begin
                        r_x     <= a;
                        r_f     <= mode;
                        r_cnt   <= 6'd0;
                        r_step  <= 3'd0;
                        r_state <= S_SEARCH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy  = (r_state == S_SEARCH);
    assign done  = (r_state == S_DONE);
    assign count = r_count;
    assign norm  = r_norm;

endmodule

// File: tb/tb_clz_clo_seq.sv
// Scoreboard bench for clz_clo_seq: stimulus pushes expectations,
// a monitor pops and compares on every done pulse.
module tb_clz_clo_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] a;
    logic        busy;
    logic        done;
    logic [5:0]  count;
    logic [31:0] norm;

    clz_clo_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .a     (a),
        .busy  (busy),
        .done  (done),
        .count (count),
        .norm  (norm)
    );

    typedef struct {
        logic [5:0]  c;
        logic [31:0] n;
        int          t;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    // Monitor: compares each done pulse against the oldest expectation.
    initial begin
        int   busy_run;
        exp_t e;
        busy_run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_run = 0;
            end else begin
                if (busy) busy_run++;
                if (done) begin
                    if (q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("count", {26'd0, count}, {26'd0, e.c});
                        check("norm", norm, e.n);
                        check("latency", cyc, e.t);
                        check("busy_cycles", busy_run, 32'd5);
                        check("busy_in_done", {31'd0, busy}, 32'd0);
                    end
                    busy_run = 0;
                end
            end
        end
    end

    task automatic issue(input logic m, input logic [31:0] v,
                         input logic [5:0] c, input logic [31:0] n);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        start = 1'b1;
        mode  = m;
        a     = v;
        q.push_back('{c, n, cyc + 6});
        @(negedge clk);
        start = 1'b0;
        mode  = ~m;
        a     = v ^ 32'hDEAD_BEEF;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) check("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic run(input logic m, input logic [31:0] v,
                       input logic [5:0] c, input logic [31:0] n);
        issue(m, v, c, n);
        wait_done();
    endtask

    initial begin
        int k;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        a     = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", {26'd0, count}, 32'd0);
        check("rst_norm", norm, 32'd0);
        rst = 1'b0;

        run(1'b0, 32'h00F0_0000, 6'd8, 32'hF000_0000);
        run(1'b0, 32'h0000_0000, 6'd32, 32'h0000_0000);
        run(1'b0, 32'h8000_0000, 6'd0, 32'h8000_0000);
        run(1'b0, 32'h0000_0001, 6'd31, 32'h8000_0000);
        run(1'b1, 32'hFFFF_FFFF, 6'd32, 32'h0000_0000);
        run(1'b1, 32'hFFF0_1234, 6'd12, 32'h0123_4000);
        run(1'b1, 32'h7FFF_FFFF, 6'd0, 32'h7FFF_FFFF);

        // start during SEARCH with another operand must be ignored
        issue(1'b0, 32'h0001_0000, 6'd15, 32'h8000_0000);
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b1;
        a     = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // start in the DONE cycle: back-to-back acceptance
        run(1'b0, 32'h00F0_0000, 6'd8, 32'hF000_0000);
        start = 1'b1;
        mode  = 1'b1;
        a     = 32'hFFF0_1234;
        q.push_back('{6'd12, 32'h0123_4000, cyc + 6});
        @(negedge clk);
        start = 1'b0;
        a     = 32'h0;
        @(negedge clk);
        wait_done();
        repeat (3) @(negedge clk);

        // reset in the third SEARCH cycle aborts without a done pulse
        run(1'b0, 32'h0000_0001, 6'd31, 32'h8000_0000);
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        a     = 32'h00F0_0000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_count", {26'd0, count}, 32'd0);
        check("abort_norm", norm, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run(1'b1, 32'hFFF0_1234, 6'd12, 32'h0123_4000);

        for (int i = 0; i < 32; i++) begin
            logic [31:0] v;
            v = 32'h8000_0000 >> i;
            run(1'b0, v, 6'(i), 32'h8000_0000);
            run(1'b1, ~v, 6'(i), 32'h7FFF_FFFF & (32'hFFFF_FFFF << i));
        end

        k = 0;
        while (q.size() > 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (8) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
